// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data_memory block.
// Port A is the CPU load/store path and port B is the loader/debug DMA path.
// At most one memory access is issued per cycle. Grants, read responses and
// the memory control/address/data outputs all come straight from flops.
module data_memory_arbiter #(
  parameter  int size   = 32,
  parameter  int length = 256,
  localparam int AW     = $clog2(length)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [size-1:0] a_wdata,
  output logic            a_gnt,
  output logic            a_rvalid,
  output logic [size-1:0] a_rdata,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [size-1:0] b_wdata,
  output logic            b_gnt,
  output logic            b_rvalid,
  output logic [size-1:0] b_rdata,
  output logic            mem_write,
  output logic            mem_read,
  output logic [AW-1:0]   mem_address,
  output logic [size-1:0] mem_write_data,
  input  logic [size-1:0] mem_read_data
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t          state, state_next;
  logic            owner, owner_next;
  logic            last_owner, last_owner_next;
  logic            lat_we, lat_we_next;
  logic            lat_re, lat_re_next;
  logic [AW-1:0]   lat_addr, lat_addr_next;
  logic [size-1:0] lat_wdata, lat_wdata_next;
  logic            a_gnt_next, b_gnt_next;
  logic            a_rvalid_next, b_rvalid_next;
  logic [size-1:0] a_rdata_next, b_rdata_next;
  logic            a_cand, b_cand, pick_b;

  // The latched access is presented to the memory directly from its flops;
  // in IDLE the latches hold zero so the memory interface is quiet.
  assign mem_write      = lat_we;
  assign mem_read       = lat_re;
  assign mem_address    = lat_addr;
  assign mem_write_data = lat_wdata;

  // Next-state, arbitration and response capture for the two-state access FSM.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    a_cand          = a_req;
    b_cand          = b_req;
    pick_b          = 1'b0;
    lat_we_next     = 1'b0;
    lat_re_next     = 1'b0;
    lat_addr_next   = {AW{1'b0}};
    lat_wdata_next  = {size{1'b0}};
    a_gnt_next      = 1'b0;
    b_gnt_next      = 1'b0;
    a_rvalid_next   = 1'b0;
    b_rvalid_next   = 1'b0;
    a_rdata_next    = a_rdata;
    b_rdata_next    = b_rdata;

    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      ACCESS: begin
        // The owner's req is still held during its grant cycle; ignore it.
        last_owner_next = owner;
        if (owner == PORT_B) begin
          b_cand = 1'b0;
          if (lat_re) begin
            b_rvalid_next = 1'b1;
            b_rdata_next  = mem_read_data;
          end else begin
            b_rvalid_next = 1'b0;
          end
        end else begin
          a_cand = 1'b0;
          if (lat_re) begin
            a_rvalid_next = 1'b1;
            a_rdata_next  = mem_read_data;
          end else begin
            a_rvalid_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A tie can only happen in IDLE; the port that did not go last wins.
    pick_b = b_cand & (~a_cand | (last_owner_next == PORT_A));

    if (a_cand | b_cand) begin
      state_next = ACCESS;
      owner_next = pick_b;
      if (pick_b) begin
        lat_we_next    = b_we;
        lat_re_next    = ~b_we;
        lat_addr_next  = b_addr;
        lat_wdata_next = b_wdata;
        b_gnt_next     = 1'b1;
      end else begin
        lat_we_next    = a_we;
        lat_re_next    = ~a_we;
        lat_addr_next  = a_addr;
        lat_wdata_next = a_wdata;
        a_gnt_next     = 1'b1;
      end
    end else begin
      state_next = IDLE;
    end
  end

  // State, latched access and all port outputs; reset aborts any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= PORT_A;
      last_owner <= PORT_B;
      lat_we     <= 1'b0;
      lat_re     <= 1'b0;
      lat_addr   <= {AW{1'b0}};
      lat_wdata  <= {size{1'b0}};
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= {size{1'b0}};
      b_rdata    <= {size{1'b0}};
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      lat_we     <= lat_we_next;
      lat_re     <= lat_re_next;
      lat_addr   <= lat_addr_next;
      lat_wdata  <= lat_wdata_next;
      a_gnt      <= a_gnt_next;
      b_gnt      <= b_gnt_next;
      a_rvalid   <= a_rvalid_next;
      b_rvalid   <= b_rvalid_next;
      a_rdata    <= a_rdata_next;
      b_rdata    <= b_rdata_next;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level arbitration model.
module tb_data_memory_arbiter;

  localparam int SIZE   = 32;
  localparam int LENGTH = 256;
  localparam int AW     = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0]   a_addr = '0;
  logic [SIZE-1:0] a_wdata = '0;
  logic            a_gnt, a_rvalid;
  logic [SIZE-1:0] a_rdata;
  logic            b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0]   b_addr = '0;
  logic [SIZE-1:0] b_wdata = '0;
  logic            b_gnt, b_rvalid;
  logic [SIZE-1:0] b_rdata;
  logic            mem_write, mem_read;
  logic [AW-1:0]   mem_address;
  logic [SIZE-1:0] mem_write_data, mem_read_data;

  logic [SIZE-1:0] mem     [LENGTH];
  logic [SIZE-1:0] ref_mem [LENGTH];
  logic            preload = 1'b1;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.size(SIZE), .length(LENGTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  function automatic logic [SIZE-1:0] init_val(input int i);
    return {8'(i), 8'hC3, 8'(255 - i), 8'h3C};
  endfunction

  // Single-port data memory: combinational read, write on posedge.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < LENGTH; i++) mem[i] <= init_val(i);
    end else if (mem_write) begin
      mem[mem_address] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_address];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < LENGTH; i++) ref_mem[i] = init_val(i);
    tick(); tick();
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write, mem_read} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write, mem_read});
    end
    checks++;
    if ({a_rdata, b_rdata, mem_address, mem_write_data} !== {(3*SIZE+AW){1'b0}}) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp zeros", a_rdata, b_rdata, mem_address, mem_write_data);
    end
    preload = 1'b0;
    rst_n = 1'b1;
    tick();
    // Reset in the middle of a write of 0xDEAD to addr 5.
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'd5; a_wdata = 32'h0000_DEAD;
    tick();
    checks++;
    if ({a_gnt, mem_write, mem_address} !== {1'b1, 1'b1, 8'd5}) begin
      errors++; $display("FAIL rst_pre_gnt got %b %b %h exp 1 1 05", a_gnt, mem_write, mem_address);
    end
    a_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write, mem_read, mem_address, mem_write_data} !== {(6+AW+SIZE){1'b0}}) begin
      errors++; $display("FAIL rst_async got %b%b%b%b%b%b %h %h exp zeros", a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write, mem_read, mem_address, mem_write_data);
    end
    tick(); tick();
    checks++;
    if (mem[5] !== ref_mem[5]) begin
      errors++; $display("FAIL rst_no_commit got %h exp %h", mem[5], ref_mem[5]);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write, mem_read} !== 6'b0) begin
      errors++; $display("FAIL rst_idle got %b exp 000000", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write, mem_read});
    end
  endtask

  task automatic test_single_a();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 32'h1234_5678;
    tick();
    checks++;
    if ({a_gnt, b_gnt, mem_write, mem_read, mem_address, mem_write_data} !== {4'b1010, 8'h10, 32'h1234_5678}) begin
      errors++; $display("FAIL single_wr got %b%b%b%b %h %h", a_gnt, b_gnt, mem_write, mem_read, mem_address, mem_write_data);
    end
    a_req = 1'b0;
    ref_mem[8'h10] = 32'h1234_5678;
    tick();
    checks++;
    if ({a_gnt, a_rvalid} !== 2'b00) begin
      errors++; $display("FAIL single_wr_after got %b exp 00", {a_gnt, a_rvalid});
    end
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    tick();
    checks++;
    if ({a_gnt, a_rvalid, mem_read, mem_write} !== 4'b1010) begin
      errors++; $display("FAIL single_rd_gnt got %b exp 1010", {a_gnt, a_rvalid, mem_read, mem_write});
    end
    a_req = 1'b0;
    tick();
    checks++;
    if ({a_gnt, a_rvalid, a_rdata} !== {2'b01, 32'h1234_5678}) begin
      errors++; $display("FAIL single_rd_data got %b%b %h exp 01 12345678", a_gnt, a_rvalid, a_rdata);
    end
    tick();
    checks++;
    if ({a_rvalid, a_rdata} !== {1'b0, 32'h1234_5678}) begin
      errors++; $display("FAIL single_rd_hold got %b %h exp 0 12345678", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'd2;
    tick();
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      errors++; $display("FAIL sim_first got %b exp 10", {a_gnt, b_gnt});
    end
    a_req = 1'b0;
    tick();
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata} !== {4'b0110, ref_mem[1]}) begin
      errors++; $display("FAIL sim_second got %b %h exp 0110 %h", {a_gnt, b_gnt, a_rvalid, b_rvalid}, a_rdata, ref_mem[1]);
    end
    b_req = 1'b0;
    tick();
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, b_rdata} !== {4'b0001, ref_mem[2]}) begin
      errors++; $display("FAIL sim_b_data got %b %h exp 0001 %h", {a_gnt, b_gnt, a_rvalid, b_rvalid}, b_rdata, ref_mem[2]);
    end
    tick();
  endtask

  task automatic test_fairness();
    logic exp_a;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'd3;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'd4;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_a = (i % 2 == 0);
      checks++;
      if ({a_gnt, b_gnt} !== {exp_a, ~exp_a}) begin
        errors++; $display("FAIL fair_%0d got %b exp %b", i, {a_gnt, b_gnt}, {exp_a, ~exp_a});
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_race();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'd7; a_wdata = 32'h0000_CAFE;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'd7;
    tick();
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      errors++; $display("FAIL race_first got %b exp 10", {a_gnt, b_gnt});
    end
    a_req = 1'b0;
    ref_mem[7] = 32'h0000_CAFE;
    tick();
    checks++;
    if ({a_gnt, b_gnt} !== 2'b01) begin
      errors++; $display("FAIL race_second got %b exp 01", {a_gnt, b_gnt});
    end
    b_req = 1'b0;
    tick();
    checks++;
    if ({b_rvalid, b_rdata} !== {1'b1, 32'h0000_CAFE}) begin
      errors++; $display("FAIL race_data got %b %h exp 1 0000cafe", b_rvalid, b_rdata);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic            exp_g;
    logic [SIZE-1:0] exp_d;
    a_we = 1'b1; a_addr = 8'hFF; a_wdata = 32'hFFFF_0001; a_req = 1'b1;
    tick(); a_req = 1'b0; tick();
    a_addr = 8'h00; a_wdata = 32'h0000_FFFE; a_req = 1'b1;
    tick(); a_req = 1'b0; tick();
    ref_mem[255] = 32'hFFFF_0001;
    ref_mem[0]   = 32'h0000_FFFE;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_g = (i % 2 == 0);
      checks++;
      if (b_gnt !== exp_g) begin
        errors++; $display("FAIL wrap_gnt_%0d got %b exp %b", i, b_gnt, exp_g);
      end
      if (b_gnt) b_addr = ~b_addr;
      if (i % 2 == 1) begin
        exp_d = ((i / 2) % 2 == 0) ? ref_mem[255] : ref_mem[0];
        checks++;
        if ({b_rvalid, b_rdata} !== {1'b1, exp_d}) begin
          errors++; $display("FAIL wrap_data_%0d got %b %h exp 1 %h", i, b_rvalid, b_rdata, exp_d);
        end
      end
    end
    b_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic            p_req [2];
    logic            p_gnt [2];
    logic            p_we  [2];
    logic [AW-1:0]   p_addr[2];
    logic [SIZE-1:0] p_wd  [2];
    logic [SIZE-1:0] e_rd  [2];
    logic [SIZE-1:0] pend_rd [2];
    logic [1:0]      e_gnt, e_rv, rv_pend;
    logic            cand0, cand1;
    int              last, w, ra;
    do_reset();
    last = 1;
    rv_pend = 2'b00;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0; p_gnt[p] = 1'b0; p_we[p] = 1'b0;
      p_addr[p] = '0; p_wd[p] = '0; e_rd[p] = '0; pend_rd[p] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int p = 0; p < 2; p++) if (rv_pend[p]) e_rd[p] = pend_rd[p];
      e_rv = rv_pend;
      rv_pend = 2'b00;
      e_gnt = 2'b00;
      // A port competes if it requested last cycle and that was not its grant cycle.
      cand0 = p_req[0] && !p_gnt[0];
      cand1 = p_req[1] && !p_gnt[1];
      if (cand0 && cand1) w = (last == 0) ? 1 : 0;
      else if (cand0) w = 0;
      else if (cand1) w = 1;
      else w = -1;
      if (w >= 0) begin
        e_gnt[w] = 1'b1;
        last = w;
        if (p_we[w]) ref_mem[p_addr[w]] = p_wd[w];
        else begin
          rv_pend[w] = 1'b1;
          pend_rd[w] = ref_mem[p_addr[w]];
        end
      end
      checks++;
      if ({a_gnt, b_gnt} !== {e_gnt[0], e_gnt[1]}) begin
        errors++; $display("FAIL rnd_gnt c=%0d got %b exp %b", c, {a_gnt, b_gnt}, {e_gnt[0], e_gnt[1]});
      end
      checks++;
      if ({a_rvalid, b_rvalid} !== {e_rv[0], e_rv[1]}) begin
        errors++; $display("FAIL rnd_rvalid c=%0d got %b exp %b", c, {a_rvalid, b_rvalid}, {e_rv[0], e_rv[1]});
      end
      checks++;
      if (a_rdata !== e_rd[0]) begin
        errors++; $display("FAIL rnd_a_rdata c=%0d got %h exp %h", c, a_rdata, e_rd[0]);
      end
      checks++;
      if (b_rdata !== e_rd[1]) begin
        errors++; $display("FAIL rnd_b_rdata c=%0d got %h exp %h", c, b_rdata, e_rd[1]);
      end
      // New request only when the port is idle or in its grant cycle.
      for (int p = 0; p < 2; p++) begin
        if (e_gnt[p] || !p_req[p]) begin
          p_req[p] = ($urandom_range(0, 2) != 0);
          p_we[p]  = 1'($urandom_range(0, 1));
          ra       = $urandom_range(0, 7);
          p_addr[p] = (ra >= 4) ? AW'(ra + 248) : AW'(ra);
          p_wd[p]  = $urandom;
        end
        p_gnt[p] = e_gnt[p];
      end
      a_req = p_req[0]; a_we = p_we[0]; a_addr = p_addr[0]; a_wdata = p_wd[0];
      b_req = p_req[1]; b_we = p_we[1]; b_addr = p_addr[1]; b_wdata = p_wd[1];
    end
    a_req = 1'b0; b_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_simultaneous();
    test_fairness();
    test_race();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
